// File: rtl/rom_loader_if.sv
// Byte-stream input and instruction-ROM write port of the boot ROM loader.
interface rom_loader_if;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_wr_data_o;
  logic        rom_wr_en_o;
  logic        core_hold_o;
  logic        done_o;
  logic        err_o;

  modport slave (
    input  start_i, byte_valid_i, byte_data_i,
    output byte_ready_o, rom_addr_o, rom_wr_data_o, rom_wr_en_o,
    output core_hold_o, done_o, err_o
  );

  modport master (
    output start_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, rom_addr_o, rom_wr_data_o, rom_wr_en_o,
    input  core_hold_o, done_o, err_o
  );
endinterface

// File: rtl/rom_loader.sv
// Boot loader: receives a little-endian word count followed by that many
// little-endian instruction words and writes them into the instruction ROM.
module rom_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic         clk,
  input  logic         rst,
  rom_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state_q,    state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q,      asm_d;
  logic [31:0] n_q,        n_d;
  logic [31:0] idx_q,      idx_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] data_q,     data_d;
  logic        wr_en_q,    wr_en_d;

  logic        byte_ready_s;
  logic        accept_s;
  logic [31:0] word_s;

  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  pos,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (pos)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      2'd3:    r[31:24] = b;
      default: r = w;
    endcase
    return r;
  endfunction

  assign byte_ready_s = (state_q == S_LEN) || (state_q == S_DATA);
  assign accept_s     = bus.byte_valid_i && byte_ready_s;
  // The completed word uses the byte arriving this cycle as its top byte.
  assign word_s       = {bus.byte_data_i, asm_q[23:0]};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    n_d        = n_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_en_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start_i) begin
          state_d    = S_LEN;
          byte_cnt_d = 2'd0;
          asm_d      = 32'h0000_0000;
          n_d        = 32'h0000_0000;
          idx_d      = 32'h0000_0000;
        end else begin
          state_d = state_q;
        end
      end

      S_LEN: begin
        if (accept_s) begin
          asm_d      = put_byte(asm_q, byte_cnt_q, bus.byte_data_i);
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            n_d   = word_s;
            idx_d = 32'h0000_0000;
            if (word_s == 32'h0000_0000) begin
              state_d = S_DONE;
            end else if (word_s > 32'(MAX_WORDS)) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_LEN;
          end
        end else begin
          state_d = S_LEN;
        end
      end

      S_DATA: begin
        if (accept_s) begin
          asm_d      = put_byte(asm_q, byte_cnt_q, bus.byte_data_i);
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_en_d = 1'b1;
            data_d  = word_s;
            addr_d  = BASE_ADDR + {idx_q[29:0], 2'b00};
            idx_d   = idx_q + 32'd1;
            if (idx_q == (n_q - 32'd1)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Loader state, counters, assembly register and ROM write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      asm_q      <= 32'h0000_0000;
      n_q        <= 32'h0000_0000;
      idx_q      <= 32'h0000_0000;
      addr_q     <= 32'h0000_0000;
      data_q     <= 32'h0000_0000;
      wr_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_en_q    <= wr_en_d;
    end
  end

  assign bus.byte_ready_o  = byte_ready_s;
  assign bus.rom_addr_o    = addr_q;
  assign bus.rom_wr_data_o = data_q;
  assign bus.rom_wr_en_o   = wr_en_q;
  // The core stays held through the final write strobe, even though the FSM is already in DONE.
  assign bus.core_hold_o   = byte_ready_s || wr_en_q;
  assign bus.done_o        = (state_q == S_DONE);
  assign bus.err_o         = (state_q == S_ERR);

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: two instances (base 0x0 and base 0x100)
// driven by a linear step sequence with hand-computed expectations.
module tb_rom_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_loader_if ifa ();
  rom_loader_if ifb ();

  rom_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(4096)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  rom_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(4096)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int total = 0;
  int bad   = 0;
  logic [31:0] a_addr[$];
  logic [31:0] a_data[$];
  logic [31:0] b_addr[$];
  logic [31:0] b_data[$];

  // One entry per cycle the strobe is high, so a stretched strobe shows up as an extra write.
  always @(negedge clk) begin
    if (ifa.rom_wr_en_o === 1'b1) begin
      a_addr.push_back(ifa.rom_addr_o);
      a_data.push_back(ifa.rom_wr_data_o);
    end
    if (ifb.rom_wr_en_o === 1'b1) begin
      b_addr.push_back(ifb.rom_addr_o);
      b_data.push_back(ifb.rom_wr_data_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_DEAD;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      ifb.byte_valid_i = v;
      ifb.byte_data_i  = d;
    end else begin
      ifa.byte_valid_i = v;
      ifa.byte_data_i  = d;
    end
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
    drive(sel, 1'b1, b);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 8'h00);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) ifb.start_i = 1'b1; else ifa.start_i = 1'b1;
    @(posedge clk);
    #1;
    if (sel) ifb.start_i = 1'b0; else ifa.start_i = 1'b0;
  endtask

  logic [7:0] v_two[12];
  logic [7:0] v_dead[8];
  logic [7:0] v_b[12];

  initial begin
    v_two  = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    v_dead = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    v_b    = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h01, 8'h00, 8'h00, 8'h80};
    ifa.start_i = 1'b0; ifa.byte_valid_i = 1'b0; ifa.byte_data_i = 8'h00;
    ifb.start_i = 1'b0; ifb.byte_valid_i = 1'b0; ifb.byte_data_i = 8'h00;

    // Reset state, observed before any clock edge.
    rst = 1'b1;
    #2;
    chk("rst_ready", {31'd0, ifa.byte_ready_o}, 32'd0);
    chk("rst_hold",  {31'd0, ifa.core_hold_o},  32'd0);
    chk("rst_done",  {31'd0, ifa.done_o},       32'd0);
    chk("rst_err",   {31'd0, ifa.err_o},        32'd0);
    chk("rst_wren",  {31'd0, ifa.rom_wr_en_o},  32'd0);
    chk("rst_addr",  ifa.rom_addr_o,            32'h0);
    chk("rst_data",  ifa.rom_wr_data_o,         32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Two-word program, back-to-back bytes.
    pulse_start(1'b0);
    chk("t1_ready", {31'd0, ifa.byte_ready_o}, 32'd1);
    chk("t1_hold",  {31'd0, ifa.core_hold_o},  32'd1);
    for (int i = 0; i < 12; i++) send_byte(1'b0, v_two[i], 0);
    chk("t1_wren_last", {31'd0, ifa.rom_wr_en_o},  32'd1);
    chk("t1_done",      {31'd0, ifa.done_o},       32'd1);
    chk("t1_hold_strb", {31'd0, ifa.core_hold_o},  32'd1);
    chk("t1_ready_off", {31'd0, ifa.byte_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("t1_wren_off",  {31'd0, ifa.rom_wr_en_o}, 32'd0);
    chk("t1_hold_off",  {31'd0, ifa.core_hold_o}, 32'd0);
    chk("t1_nwr",       a_addr.size(),            32'd2);
    chk("t1_addr0",     qget(a_addr, 0),          32'h0000_0000);
    chk("t1_data0",     qget(a_data, 0),          32'h0000_0013);
    chk("t1_addr1",     qget(a_addr, 1),          32'h0000_0004);
    chk("t1_data1",     qget(a_data, 1),          32'h0010_0093);
    chk("t1_addr_hold", ifa.rom_addr_o,           32'h0000_0004);
    chk("t1_data_hold", ifa.rom_wr_data_o,        32'h0010_0093);
    send_byte(1'b0, 8'hFF, 1);
    chk("t1_idle_byte_done", {31'd0, ifa.done_o}, 32'd1);
    chk("t1_idle_byte_nwr",  a_addr.size(),       32'd2);

    // Zero-length program.
    pulse_start(1'b0);
    chk("t2_done_clr", {31'd0, ifa.done_o}, 32'd0);
    for (int i = 0; i < 4; i++) send_byte(1'b0, 8'h00, 0);
    chk("t2_done", {31'd0, ifa.done_o},      32'd1);
    chk("t2_hold", {31'd0, ifa.core_hold_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("t2_nwr", a_addr.size(), 32'd2);

    // Word count 4097 is one over the limit.
    pulse_start(1'b0);
    send_byte(1'b0, 8'h01, 0);
    send_byte(1'b0, 8'h10, 0);
    send_byte(1'b0, 8'h00, 0);
    send_byte(1'b0, 8'h00, 0);
    chk("t3_err",   {31'd0, ifa.err_o},        32'd1);
    chk("t3_ready", {31'd0, ifa.byte_ready_o}, 32'd0);
    chk("t3_hold",  {31'd0, ifa.core_hold_o},  32'd0);
    chk("t3_done",  {31'd0, ifa.done_o},       32'd0);
    @(posedge clk);
    #1;
    chk("t3_nwr", a_addr.size(), 32'd2);
    pulse_start(1'b0);
    chk("t3_err_clr", {31'd0, ifa.err_o},        32'd0);
    chk("t3_ready_on", {31'd0, ifa.byte_ready_o}, 32'd1);

    // N=2 with gaps; a start pulse mid-DATA must be ignored.
    send_byte(1'b0, 8'h02, 1);
    send_byte(1'b0, 8'h00, 0);
    send_byte(1'b0, 8'h00, 2);
    send_byte(1'b0, 8'h00, 0);
    send_byte(1'b0, v_dead[0], 3);
    send_byte(1'b0, v_dead[1], 1);
    pulse_start(1'b0);
    for (int i = 2; i < 8; i++) send_byte(1'b0, v_dead[i], i % 3);
    chk("t4_done", {31'd0, ifa.done_o}, 32'd1);
    @(posedge clk);
    #1;
    chk("t4_nwr",   a_addr.size(),   32'd4);
    chk("t4_addr0", qget(a_addr, 2), 32'h0000_0000);
    chk("t4_data0", qget(a_data, 2), 32'hDEAD_BEEF);
    chk("t4_addr1", qget(a_addr, 3), 32'h0000_0004);
    chk("t4_data1", qget(a_data, 3), 32'h1234_5678);

    // Reset after six data bytes of a three-word session.
    pulse_start(1'b0);
    send_byte(1'b0, 8'h03, 0);
    send_byte(1'b0, 8'h00, 0);
    send_byte(1'b0, 8'h00, 0);
    send_byte(1'b0, 8'h00, 0);
    send_byte(1'b0, 8'h11, 0);
    send_byte(1'b0, 8'h22, 0);
    send_byte(1'b0, 8'h33, 0);
    send_byte(1'b0, 8'h44, 0);
    send_byte(1'b0, 8'h55, 0);
    send_byte(1'b0, 8'h66, 0);
    chk("t5_nwr_pre",  a_addr.size(),   32'd5);
    chk("t5_data_pre", qget(a_data, 4), 32'h4433_2211);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_ready", {31'd0, ifa.byte_ready_o}, 32'd0);
    chk("t5_hold",  {31'd0, ifa.core_hold_o},  32'd0);
    chk("t5_addr",  ifa.rom_addr_o,            32'h0);
    chk("t5_data",  ifa.rom_wr_data_o,         32'h0);
    chk("t5_done",  {31'd0, ifa.done_o},       32'd0);
    chk("t5_err",   {31'd0, ifa.err_o},        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_byte(1'b0, 8'h77, 0);
    send_byte(1'b0, 8'h88, 0);
    send_byte(1'b0, 8'h99, 0);
    send_byte(1'b0, 8'hAA, 0);
    @(posedge clk);
    #1;
    chk("t5_nwr_post",   a_addr.size(),             32'd5);
    chk("t5_ready_post", {31'd0, ifa.byte_ready_o}, 32'd0);
    chk("t5_done_post",  {31'd0, ifa.done_o},       32'd0);

    // Base address 0x100, three words, random gaps mixed with back-to-back bytes.
    pulse_start(1'b1);
    send_byte(1'b1, 8'h03, 0);
    send_byte(1'b1, 8'h00, 1);
    send_byte(1'b1, 8'h00, 0);
    send_byte(1'b1, 8'h00, 0);
    for (int i = 0; i < 12; i++) begin
      send_byte(1'b1, v_b[i], (i % 3 == 0) ? int'($urandom_range(0, 3)) : 0);
    end
    chk("t6_done", {31'd0, ifb.done_o}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_nwr",   b_addr.size(),   32'd3);
    chk("t6_addr0", qget(b_addr, 0), 32'h0000_0100);
    chk("t6_data0", qget(b_data, 0), 32'h0000_0513);
    chk("t6_addr1", qget(b_addr, 1), 32'h0000_0104);
    chk("t6_data1", qget(b_data, 1), 32'hCAFE_F00D);
    chk("t6_addr2", qget(b_addr, 2), 32'h0000_0108);
    chk("t6_data2", qget(b_data, 2), 32'h8000_0001);
    chk("t6_hold",  {31'd0, ifb.core_hold_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
